fanout_tree_monitor: RTL and testbench

- Checks the buffered inverter fanout tree from its output side.
- Samples the tree's `NUM_OUT` leaf outputs and the tree's source signal.
- Flags any leaf that disagrees with the expected value, which is the inverted source.
- Suppresses comparison for a settle window after each source transition, counts mismatch cycles over a programmable check window, and reports sticky per-leaf error bits.

---
 rtl/fanout_tree_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_fanout_tree_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fanout_tree_monitor.sv
// Output-side checker for a buffered inverter fanout tree: compares every leaf against ~source,
// masks settle windows after source edges, and gathers run statistics. Define FANOUT_MON_SKEW_EN for skew tracking.
module fanout_tree_monitor #(
    parameter int NUM_OUT    = 20,
    parameter int SETTLE_CYC = 2,
    parameter int WINDOW     = 256,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ref_in,
    input  logic [NUM_OUT-1:0] tree_out,
    input  logic               arm,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic               err_flag,
    output logic [NUM_OUT-1:0] err_mask,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   chk_count,
    output logic [7:0]         skew_max
);

    localparam int SW = $clog2(SETTLE_CYC + 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic               ref_q, ref_qq;
    logic [NUM_OUT-1:0] out_q;
    logic [SW-1:0]      settle_q, settle_d;
    logic [SW-1:0]      fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   chk_q, chk_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [CNT_W:0]     chk_nxt;
    logic [NUM_OUT-1:0] mm;
    logic               src_chg;
    logic               suppress;
    logic               compare;
    logic               clr_stats;

    // Input sample stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q  <= 1'b0;
            ref_qq <= 1'b0;
            out_q  <= '0;
        end else begin
            ref_q  <= ref_in;
            ref_qq <= ref_q;
            out_q  <= tree_out;
        end
    end

    assign src_chg  = ref_q ^ ref_qq;
    assign mm       = out_q ^ {NUM_OUT{~ref_q}};
    assign suppress = src_chg || (settle_q != '0);
    assign compare  = (state_q == S_CHECK) && !suppress;
    assign chk_nxt  = {1'b0, chk_q} + 1'b1;

    // The source-edge masking runs regardless of FSM state so an edge just before CHECK is still hidden.
    always_comb begin
        settle_d = settle_q;
        if (src_chg) begin
            settle_d = SW'(SETTLE_CYC);
        end else if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        clr_stats = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d   = S_SETTLE;
                    fcnt_d    = SW'(SETTLE_CYC);
                    clr_stats = 1'b1;
                end
            end
            S_SETTLE: begin
                if (fcnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (compare && (chk_nxt == (CNT_W+1)'(WINDOW))) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d   = S_IDLE;
            fcnt_d    = '0;
            clr_stats = 1'b1;
        end
    end

    always_comb begin
        chk_d  = chk_q;
        err_d  = err_q;
        mask_d = mask_q;
        if (clr_stats) begin
            chk_d  = '0;
            err_d  = '0;
            mask_d = '0;
        end else if (compare) begin
            chk_d  = chk_nxt[CNT_W-1:0];
            mask_d = mask_q | mm;
            if (mm != '0) begin
                err_d = sat_inc(err_q);
            end
        end
    end

    // Control and statistics stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            settle_q <= '0;
            chk_q    <= '0;
            err_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            settle_q <= settle_d;
            chk_q    <= chk_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
        end
    end

`ifdef FANOUT_MON_SKEW_EN
    logic [7:0] lag_q, lag_d;
    logic       lag_act_q, lag_act_d;
    logic [7:0] skew_q, skew_d;

    // Lag counts mismatching cycles from the source edge (inclusive) to the first fully matching cycle.
    always_comb begin
        lag_d     = lag_q;
        lag_act_d = lag_act_q;
        skew_d    = skew_q;
        if (src_chg) begin
            lag_d     = (mm != '0) ? 8'd1 : 8'd0;
            lag_act_d = (mm != '0);
        end else if (lag_act_q) begin
            if (mm != '0) begin
                lag_d = (&lag_q) ? lag_q : lag_q + 8'd1;
            end else begin
                lag_act_d = 1'b0;
                if (((state_q == S_SETTLE) || (state_q == S_CHECK)) && (lag_q > skew_q)) begin
                    skew_d = lag_q;
                end
            end
        end
        if (clr_stats) begin
            skew_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag_q     <= '0;
            lag_act_q <= 1'b0;
            skew_q    <= '0;
        end else begin
            lag_q     <= lag_d;
            lag_act_q <= lag_act_d;
            skew_q    <= skew_d;
        end
    end

    assign skew_max = skew_q;
`else
    assign skew_max = 8'd0;
`endif

    assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign err_flag  = |mask_q;
    assign err_mask  = mask_q;
    assign err_count = err_q;
    assign chk_count = chk_q;

endmodule

// File: tb/tb_fanout_tree_monitor.sv
// Directed bench for fanout_tree_monitor: main instance with an 8-cycle window, plus a narrow-counter instance.
module tb_fanout_tree_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_in = 1'b0;
    logic [19:0] tree_out = 20'hFFFFF;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic        busy, done, err_flag;
    logic [19:0] err_mask;
    logic [15:0] err_count, chk_count;
    logic [7:0]  skew_max;

    logic [19:0] tree2 = 20'h00000;
    logic        arm2 = 1'b0;
    logic        busy2, done2, err_flag2;
    logic [19:0] err_mask2;
    logic [4:0]  err_count2, chk_count2;
    logic [7:0]  skew_max2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fanout_tree_monitor #(.NUM_OUT(20), .SETTLE_CYC(2), .WINDOW(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .tree_out(tree_out),
        .arm(arm), .clear(clear), .busy(busy), .done(done), .err_flag(err_flag),
        .err_mask(err_mask), .err_count(err_count), .chk_count(chk_count), .skew_max(skew_max)
    );

    fanout_tree_monitor #(.NUM_OUT(20), .SETTLE_CYC(2), .WINDOW(31), .CNT_W(5)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .tree_out(tree2),
        .arm(arm2), .clear(clear), .busy(busy2), .done(done2), .err_flag(err_flag2),
        .err_mask(err_mask2), .err_count(err_count2), .chk_count(chk_count2), .skew_max(skew_max2)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) chk_val(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #2;
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);
        chk_val("rst_chk", 32'(chk_count), 32'd0);
        chk_val("rst_mask", 32'(err_mask), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // clean run: busy cycles 1..11, done from 12
        start_run();
        chk_val("clean_busy_c1", 32'(busy), 32'd1);
        for (int i = 2; i <= 11; i++) begin
            tick();
            chk_val($sformatf("clean_busy_c%0d", i), 32'(busy), 32'd1);
        end
        tick();
        chk_val("clean_done_c12", 32'(done), 32'd1);
        chk_val("clean_busy_c12", 32'(busy), 32'd0);
        chk_val("clean_chk", 32'(chk_count), 32'd8);
        chk_val("clean_err", 32'(err_count), 32'd0);
        chk_val("clean_mask", 32'(err_mask), 32'd0);
        chk_val("clean_flag", 32'(err_flag), 32'd0);

        // stuck leaf bit 7 for three compared cycles
        start_run();
        repeat (4) tick();
        tree_out = 20'hFFF7F;
        repeat (3) tick();
        tree_out = 20'hFFFFF;
        wait_done("stuck_done_timeout");
        chk_val("stuck_err", 32'(err_count), 32'd3);
        chk_val("stuck_mask", 32'(err_mask), 32'h00080);
        chk_val("stuck_flag", 32'(err_flag), 32'd1);
        chk_val("stuck_chk", 32'(chk_count), 32'd8);

        // source edge 0->1, leaves follow one cycle later
        start_run();
        repeat (5) tick();
        ref_in = 1'b1;
        tick();
        tree_out = 20'h00000;
        wait_done("follow_done_timeout");
        chk_val("follow_err", 32'(err_count), 32'd0);
        chk_val("follow_mask", 32'(err_mask), 32'd0);
        chk_val("follow_chk", 32'(chk_count), 32'd8);
`ifdef FANOUT_MON_SKEW_EN
        chk_val("follow_skew", 32'(skew_max), 32'd1);
`else
        chk_val("follow_skew", 32'(skew_max), 32'd0);
`endif

        // source edge 1->0, bit 3 lags four cycles
        start_run();
        repeat (5) tick();
        ref_in = 1'b0;
        tick();
        tree_out = 20'hFFFF7;
        repeat (3) tick();
        tree_out = 20'hFFFFF;
        wait_done("lag_done_timeout");
        chk_val("lag_err", 32'(err_count), 32'd1);
        chk_val("lag_mask", 32'(err_mask), 32'h00008);
        chk_val("lag_flag", 32'(err_flag), 32'd1);
`ifdef FANOUT_MON_SKEW_EN
        chk_val("lag_skew", 32'(skew_max), 32'd4);
`else
        chk_val("lag_skew", 32'(skew_max), 32'd0);
`endif

        // asynchronous reset mid-CHECK with err_count = 5
        start_run();
        repeat (4) tick();
        tree_out = 20'hFFFFE;
        repeat (5) tick();
        tree_out = 20'hFFFFF;
        tick();
        chk_val("midrst_pre_err", 32'(err_count), 32'd5);
        chk_val("midrst_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_val("midrst_busy", 32'(busy), 32'd0);
        chk_val("midrst_done", 32'(done), 32'd0);
        chk_val("midrst_err", 32'(err_count), 32'd0);
        chk_val("midrst_chk", 32'(chk_count), 32'd0);
        chk_val("midrst_mask", 32'(err_mask), 32'd0);
        chk_val("midrst_flag", 32'(err_flag), 32'd0);
        chk_val("midrst_skew", 32'(skew_max), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        chk_val("midrst_idle_busy", 32'(busy), 32'd0);
        chk_val("midrst_idle_done", 32'(done), 32'd0);

        // clear beats arm, then a lone arm starts a run
        start_run();
        repeat (6) tick();
        chk_val("prec_pre_chk_nz", 32'(chk_count != 16'd0), 32'd1);
        clear = 1'b1;
        arm = 1'b1;
        tick();
        clear = 1'b0;
        arm = 1'b0;
        chk_val("prec_busy", 32'(busy), 32'd0);
        chk_val("prec_done", 32'(done), 32'd0);
        chk_val("prec_chk", 32'(chk_count), 32'd0);
        chk_val("prec_err", 32'(err_count), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk_val("prec_arm_busy", 32'(busy), 32'd1);
        chk_val("prec_arm_chk", 32'(chk_count), 32'd0);

        // narrow counter: all leaves wrong for 40 cycles
        clear = 1'b1;
        tick();
        clear = 1'b0;
        arm2 = 1'b1;
        tick();
        arm2 = 1'b0;
        repeat (40) tick();
        chk_val("sat_err", 32'(err_count2), 32'd31);
        chk_val("sat_chk", 32'(chk_count2), 32'd31);
        chk_val("sat_done", 32'(done2), 32'd1);
        chk_val("sat_mask", 32'(err_mask2), 32'hFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
